// File: rtl/cache_line_iter_if.sv
// Request/line bus of the reference-cache line iterator.
// The requester/consumer side uses modport master, the iterator uses modport slave.
// Optional macro CACHE_LINE_ITER_COUNT_EN adds the 4-bit line_idx signal.
interface cache_line_iter_if #(
  parameter int X_ADDR_WDTH = 12,
  parameter int Y_ADDR_WDTH = 12,
  parameter int C_L_H_SIZE  = 3,
  parameter int C_L_V_SIZE  = 3,
  parameter int DIM_WDTH    = 4
);

  // Request side
  logic                              req_valid;
  logic                              req_ready;
  logic [X_ADDR_WDTH-1:0]            start_x;
  logic [Y_ADDR_WDTH-1:0]            start_y;
  logic [DIM_WDTH-1:0]               blk_width;
  logic [DIM_WDTH-1:0]               blk_height;

  // Line side
  logic                              line_valid;
  logic                              line_ready;
  logic [X_ADDR_WDTH-C_L_H_SIZE-1:0] x_addr;
  logic [Y_ADDR_WDTH-C_L_V_SIZE-1:0] y_addr;
  logic                              line_first;
  logic                              line_last;

`ifdef CACHE_LINE_ITER_COUNT_EN
  logic [3:0]                        line_idx;

  modport master (
    output req_valid, start_x, start_y, blk_width, blk_height, line_ready,
    input  req_ready, line_valid, x_addr, y_addr, line_first, line_last, line_idx
  );

  modport slave (
    input  req_valid, start_x, start_y, blk_width, blk_height, line_ready,
    output req_ready, line_valid, x_addr, y_addr, line_first, line_last, line_idx
  );
`else
  modport master (
    output req_valid, start_x, start_y, blk_width, blk_height, line_ready,
    input  req_ready, line_valid, x_addr, y_addr, line_first, line_last
  );

  modport slave (
    input  req_valid, start_x, start_y, blk_width, blk_height, line_ready,
    output req_ready, line_valid, x_addr, y_addr, line_first, line_last
  );
`endif

endinterface

// File: rtl/cache_line_iter.sv
// cache_line_iter: walks every cache line overlapped by a reference block,
// in raster order, one line per cycle, with valid/ready on both sides.
// A synchronous flush aborts the walk. Optional macro CACHE_LINE_ITER_COUNT_EN
// adds a 4-bit index of the line currently presented (line_idx).
module cache_line_iter #(
  parameter int X_ADDR_WDTH = 12,
  parameter int Y_ADDR_WDTH = 12,
  parameter int C_L_H_SIZE  = 3,
  parameter int C_L_V_SIZE  = 3,
  parameter int DIM_WDTH    = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  cache_line_iter_if.slave bus
);

  localparam int XL_W = X_ADDR_WDTH - C_L_H_SIZE;
  localparam int YL_W = Y_ADDR_WDTH - C_L_V_SIZE;
  localparam int XS_W = XL_W + 1;
  localparam int YS_W = YL_W + 1;

  localparam logic [XL_W-1:0] X_ONE = {{(XL_W-1){1'b0}}, 1'b1};
  localparam logic [YL_W-1:0] Y_ONE = {{(YL_W-1){1'b0}}, 1'b1};

  typedef enum logic {
    IDLE,
    ITER
  } state_t;

  state_t            state;

  logic [XL_W-1:0]   x_lo_q;
  logic [XL_W-1:0]   x_hi_q;
  logic [YL_W-1:0]   y_hi_q;
  logic [XL_W-1:0]   x_addr_q;
  logic [YL_W-1:0]   y_addr_q;
  logic              req_ready_q;
  logic              line_valid_q;
  logic              first_q;
  logic              last_q;

  logic [X_ADDR_WDTH:0] x_sum;
  logic [Y_ADDR_WDTH:0] y_sum;
  logic [XS_W-1:0]      x_sum_line;
  logic [YS_W-1:0]      y_sum_line;
  logic [XL_W-1:0]      req_x_lo;
  logic [XL_W-1:0]      req_x_hi;
  logic [YL_W-1:0]      req_y_lo;
  logic [YL_W-1:0]      req_y_hi;

  logic                 x_more;
  logic                 y_more;
  logic [XL_W-1:0]      nxt_x;
  logic [YL_W-1:0]      nxt_y;
  logic                 nxt_last;

  // Line bounds of the incoming request; a carry out of the far edge clamps to the last line index
  always_comb begin
    x_sum      = {1'b0, bus.start_x} + {{(X_ADDR_WDTH + 1 - DIM_WDTH){1'b0}}, bus.blk_width};
    y_sum      = {1'b0, bus.start_y} + {{(Y_ADDR_WDTH + 1 - DIM_WDTH){1'b0}}, bus.blk_height};
    x_sum_line = XS_W'(x_sum >> C_L_H_SIZE);
    y_sum_line = YS_W'(y_sum >> C_L_V_SIZE);
    req_x_lo   = bus.start_x[X_ADDR_WDTH-1:C_L_H_SIZE];
    req_y_lo   = bus.start_y[Y_ADDR_WDTH-1:C_L_V_SIZE];
    req_x_hi   = x_sum_line[XL_W] ? '1 : x_sum_line[XL_W-1:0];
    req_y_hi   = y_sum_line[YL_W] ? '1 : y_sum_line[YL_W-1:0];
  end

  // Raster step: move right along the row, otherwise wrap to x_lo on the next row
  always_comb begin
    x_more   = x_addr_q < x_hi_q;
    y_more   = y_addr_q < y_hi_q;
    nxt_x    = x_more ? (x_addr_q + X_ONE) : x_lo_q;
    nxt_y    = x_more ? y_addr_q : (y_addr_q + Y_ONE);
    nxt_last = (nxt_x == x_hi_q) && (nxt_y == y_hi_q);
  end

  // Walk FSM with registered outputs; flush beats any request or line handshake
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      x_lo_q       <= '0;
      x_hi_q       <= '0;
      y_hi_q       <= '0;
      x_addr_q     <= '0;
      y_addr_q     <= '0;
      req_ready_q  <= 1'b1;
      line_valid_q <= 1'b0;
      first_q      <= 1'b0;
      last_q       <= 1'b0;
    end else if (flush) begin
      state        <= IDLE;
      req_ready_q  <= 1'b1;
      line_valid_q <= 1'b0;
      first_q      <= 1'b0;
      last_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            x_lo_q       <= req_x_lo;
            x_hi_q       <= req_x_hi;
            y_hi_q       <= req_y_hi;
            x_addr_q     <= req_x_lo;
            y_addr_q     <= req_y_lo;
            first_q      <= 1'b1;
            last_q       <= (req_x_lo == req_x_hi) && (req_y_lo == req_y_hi);
            line_valid_q <= 1'b1;
            req_ready_q  <= 1'b0;
            state        <= ITER;
          end
        end
        ITER: begin
          if (bus.line_ready) begin
            if (x_more || y_more) begin
              x_addr_q <= nxt_x;
              y_addr_q <= nxt_y;
              first_q  <= 1'b0;
              last_q   <= nxt_last;
            end else begin
              line_valid_q <= 1'b0;
              req_ready_q  <= 1'b1;
              first_q      <= 1'b0;
              last_q       <= 1'b0;
              state        <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef CACHE_LINE_ITER_COUNT_EN
  logic [3:0] idx_q;

  // Index of the presented line; holds on the final handshake so it stays within the walk
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q <= 4'd0;
    end else if (flush) begin
      idx_q <= 4'd0;
    end else if (state == IDLE) begin
      if (bus.req_valid) begin
        idx_q <= 4'd0;
      end
    end else if (bus.line_ready && (x_more || y_more)) begin
      idx_q <= idx_q + 4'd1;
    end
  end

  assign bus.line_idx = idx_q;
`endif

  assign bus.req_ready  = req_ready_q;
  assign bus.line_valid = line_valid_q;
  assign bus.x_addr     = x_addr_q;
  assign bus.y_addr     = y_addr_q;
  assign bus.line_first = first_q;
  assign bus.line_last  = last_q;

endmodule

// File: tb/tb_cache_line_iter.sv
// Self-checking bench for cache_line_iter: directed table, multi-cycle corner
// sequences (backpressure, flush, reset) and randomized requests checked
// against a raster-walk reference model.
module tb_cache_line_iter;

  localparam int XW = 12;
  localparam int YW = 12;
  localparam int CH = 3;
  localparam int CV = 3;
  localparam int DW = 4;
  localparam int X_PIX_MAX  = (1 << XW) - 1;
  localparam int Y_PIX_MAX  = (1 << YW) - 1;
  localparam int X_LINE_MAX = (1 << (XW - CH)) - 1;
  localparam int Y_LINE_MAX = (1 << (YW - CV)) - 1;

  typedef struct {
    int x;
    int y;
    bit first;
    bit last;
  } beat_t;

  typedef struct {
    int sx;
    int sy;
    int w;
    int h;
    int x_lo;
    int y_lo;
    int x_hi;
    int y_hi;
    int n;
  } vec_t;

  logic clk;
  logic reset_n;
  logic flush;

  int vec_count;
  int miscompares;

  beat_t exp_q[$];
  int obs_count;
  int obs_first_x, obs_first_y, obs_last_x, obs_last_y;

  vec_t vecs[8];

  cache_line_iter_if #(
    .X_ADDR_WDTH(XW), .Y_ADDR_WDTH(YW), .C_L_H_SIZE(CH), .C_L_V_SIZE(CV), .DIM_WDTH(DW)
  ) bus ();

  cache_line_iter #(
    .X_ADDR_WDTH(XW), .Y_ADDR_WDTH(YW), .C_L_H_SIZE(CH), .C_L_V_SIZE(CV), .DIM_WDTH(DW)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .flush  (flush),
    .bus    (bus)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int act, input int exp);
    vec_count++;
    if (act != exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: every line whose pixel span meets the block, rows top to bottom
  task automatic buildModel(input int sx, input int sy, input int w, input int h);
    int xlo, xhi, ylo, yhi;
    beat_t b;
    exp_q.delete();
    xlo = sx / (1 << CH);
    ylo = sy / (1 << CV);
    xhi = (sx + w > X_PIX_MAX) ? X_LINE_MAX : (sx + w) / (1 << CH);
    yhi = (sy + h > Y_PIX_MAX) ? Y_LINE_MAX : (sy + h) / (1 << CV);
    for (int y = ylo; y <= yhi; y++) begin
      for (int x = xlo; x <= xhi; x++) begin
        b.x = x;
        b.y = y;
        b.first = (x == xlo) && (y == ylo);
        b.last  = (x == xhi) && (y == yhi);
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic applyStimulus(input int sx, input int sy, input int w, input int h);
    int waitc;
    waitc = 0;
    @(negedge clk);
    while (!bus.req_ready && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    checkOutput("req_ready_before_req", int'(bus.req_ready), 1);
    bus.start_x    = XW'(sx);
    bus.start_y    = YW'(sy);
    bus.blk_width  = DW'(w);
    bus.blk_height = DW'(h);
    bus.req_valid  = 1'b1;
    @(posedge clk);
  endtask

  task automatic runWalk(input int stall_beat, input int stall_len, input int flush_beat,
                         input int reset_beat, input bit rnd);
    int beats, stall_left, cycles;
    bit done, rdy;
    beat_t e;
    beats = 0;
    stall_left = stall_len;
    cycles = 0;
    done = 1'b0;
    obs_count = 0;
    while (!done) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      cycles++;
      if (cycles > 300) begin
        checkOutput("walk_timeout", 1, 0);
        exp_q.delete();
        done = 1'b1;
      end else if (exp_q.size() == 0) begin
        checkOutput("post_walk_line_valid", int'(bus.line_valid), 0);
        checkOutput("post_walk_req_ready", int'(bus.req_ready), 1);
        done = 1'b1;
      end else begin
        e = exp_q[0];
        checkOutput("line_valid", int'(bus.line_valid), 1);
        checkOutput("x_addr", int'(bus.x_addr), e.x);
        checkOutput("y_addr", int'(bus.y_addr), e.y);
        checkOutput("line_first", int'(bus.line_first), int'(e.first));
        checkOutput("line_last", int'(bus.line_last), int'(e.last));
        if (flush_beat == beats + 1) begin
          flush = 1'b1;
          bus.line_ready = 1'b1;
          bus.start_x = 12'd64;
          bus.start_y = 12'd64;
          bus.blk_width = 4'd0;
          bus.blk_height = 4'd0;
          bus.req_valid = 1'b1;
          @(negedge clk);
          flush = 1'b0;
          bus.req_valid = 1'b0;
          checkOutput("flush_line_valid", int'(bus.line_valid), 0);
          checkOutput("flush_req_ready", int'(bus.req_ready), 1);
          @(negedge clk);
          checkOutput("flush_no_accept", int'(bus.line_valid), 0);
          exp_q.delete();
          done = 1'b1;
        end else if (reset_beat == beats + 1) begin
          reset_n = 1'b0;
          #1;
          checkOutput("rst_req_ready", int'(bus.req_ready), 1);
          checkOutput("rst_line_valid", int'(bus.line_valid), 0);
          checkOutput("rst_x_addr", int'(bus.x_addr), 0);
          checkOutput("rst_y_addr", int'(bus.y_addr), 0);
          checkOutput("rst_line_first", int'(bus.line_first), 0);
          checkOutput("rst_line_last", int'(bus.line_last), 0);
          @(negedge clk);
          reset_n = 1'b1;
          bus.line_ready = 1'b1;
          for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("post_rst_line_valid", int'(bus.line_valid), 0);
            checkOutput("post_rst_req_ready", int'(bus.req_ready), 1);
          end
          exp_q.delete();
          done = 1'b1;
        end else begin
          rdy = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
          if (stall_beat == beats + 1 && stall_left > 0) begin
            rdy = 1'b0;
            stall_left--;
          end
          bus.line_ready = rdy;
          if (rdy && bus.line_valid) begin
            if (obs_count == 0) begin
              obs_first_x = int'(bus.x_addr);
              obs_first_y = int'(bus.y_addr);
            end
            obs_last_x = int'(bus.x_addr);
            obs_last_y = int'(bus.y_addr);
            obs_count++;
            void'(exp_q.pop_front());
            beats++;
          end
        end
      end
    end
  endtask

  initial begin
    int sx, sy, w, h;
    vec_count   = 0;
    miscompares = 0;
    reset_n = 1'b0;
    flush   = 1'b0;
    bus.req_valid  = 1'b0;
    bus.start_x    = '0;
    bus.start_y    = '0;
    bus.blk_width  = '0;
    bus.blk_height = '0;
    bus.line_ready = 1'b0;

    vecs[0] = '{0,    0,    7,  7,  0,   0,   0,   0,   1};
    vecs[1] = '{5,    6,    15, 3,  0,   0,   2,   1,   6};
    vecs[2] = '{4090, 0,    15, 0,  511, 0,   511, 0,   1};
    vecs[3] = '{8,    8,    0,  0,  1,   1,   1,   1,   1};
    vecs[4] = '{7,    7,    1,  1,  0,   0,   1,   1,   4};
    vecs[5] = '{100,  4090, 15, 15, 12,  511, 14,  511, 3};
    vecs[6] = '{4095, 4095, 15, 15, 511, 511, 511, 511, 1};
    vecs[7] = '{1,    1,    15, 15, 0,   0,   2,   2,   9};

    repeat (2) @(negedge clk);
    checkOutput("reset_req_ready", int'(bus.req_ready), 1);
    checkOutput("reset_line_valid", int'(bus.line_valid), 0);
    checkOutput("reset_x_addr", int'(bus.x_addr), 0);
    checkOutput("reset_y_addr", int'(bus.y_addr), 0);
    checkOutput("reset_line_first", int'(bus.line_first), 0);
    checkOutput("reset_line_last", int'(bus.line_last), 0);
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("idle_line_valid", int'(bus.line_valid), 0);

    for (int i = 0; i < 8; i++) begin
      buildModel(vecs[i].sx, vecs[i].sy, vecs[i].w, vecs[i].h);
      applyStimulus(vecs[i].sx, vecs[i].sy, vecs[i].w, vecs[i].h);
      runWalk(0, 0, 0, 0, 1'b0);
      checkOutput($sformatf("vec%0d_beats", i), obs_count, vecs[i].n);
      checkOutput($sformatf("vec%0d_first_x", i), obs_first_x, vecs[i].x_lo);
      checkOutput($sformatf("vec%0d_first_y", i), obs_first_y, vecs[i].y_lo);
      checkOutput($sformatf("vec%0d_last_x", i), obs_last_x, vecs[i].x_hi);
      checkOutput($sformatf("vec%0d_last_y", i), obs_last_y, vecs[i].y_hi);
    end

    $display("[TB] backpressure on beat 2");
    buildModel(5, 6, 15, 3);
    applyStimulus(5, 6, 15, 3);
    runWalk(2, 3, 0, 0, 1'b0);
    checkOutput("bp_beats", obs_count, 6);

    $display("[TB] flush on beat 3");
    buildModel(5, 6, 15, 3);
    applyStimulus(5, 6, 15, 3);
    runWalk(0, 0, 3, 0, 1'b0);
    buildModel(17, 30, 9, 2);
    applyStimulus(17, 30, 9, 2);
    runWalk(0, 0, 0, 0, 1'b0);
    checkOutput("after_flush_first_x", obs_first_x, 2);
    checkOutput("after_flush_first_y", obs_first_y, 3);

    $display("[TB] reset on beat 4");
    buildModel(5, 6, 15, 3);
    applyStimulus(5, 6, 15, 3);
    runWalk(0, 0, 0, 4, 1'b0);
    buildModel(5, 6, 15, 3);
    applyStimulus(5, 6, 15, 3);
    runWalk(0, 0, 0, 0, 1'b1);
    checkOutput("after_reset_beats", obs_count, 6);

    $display("[TB] randomized requests");
    for (int r = 0; r < 40; r++) begin
      sx = (r % 5 == 0) ? $urandom_range(4080, 4095) : $urandom_range(0, 4095);
      sy = (r % 7 == 0) ? $urandom_range(4080, 4095) : $urandom_range(0, 4095);
      w  = $urandom_range(0, 15);
      h  = $urandom_range(0, 15);
      buildModel(sx, sy, w, h);
      applyStimulus(sx, sy, w, h);
      runWalk(0, 0, 0, 0, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule

// File: doc/cache_line_iter.md
# cache_line_iter

Request-side iterator for the reference cache. It accepts one reference-block request per handshake: block origin plus inclusive extent minus one. It walks every cache line the block overlaps, in raster order, one line per cycle. Each emitted (x_addr, y_addr) pair in cache-line units feeds the destination-enable check and the tag lookup stage directly downstream. Backpressure uses a valid/ready handshake; a synchronous flush aborts the walk.

## Interface
Parameters:
- X_ADDR_WDTH, 12, pixel x-coordinate width
- Y_ADDR_WDTH, 12, pixel y-coordinate width
- C_L_H_SIZE, 3, log2 cache-line width in pixels
- C_L_V_SIZE, 3, log2 cache-line height in pixels
- DIM_WDTH, 4, width of blk_width/blk_height

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous abort, highest priority
- req_valid  in  1  request present
- req_ready  out  1  iterator idle, request accepted on valid&&ready
- start_x  in  X_ADDR_WDTH  block left pixel
- start_y  in  Y_ADDR_WDTH  block top pixel
- blk_width  in  DIM_WDTH  block width minus 1
- blk_height  in  DIM_WDTH  block height minus 1
- line_valid  out  1  x_addr/y_addr valid
- line_ready  in  1  downstream accepts line
- x_addr  out  X_ADDR_WDTH-C_L_H_SIZE  cache-line column
- y_addr  out  Y_ADDR_WDTH-C_L_V_SIZE  cache-line row
- line_first  out  1  first line of request
- line_last  out  1  final line of request

## Operation
- FSM states: IDLE and ITER.
- IDLE: req_ready=1, line_valid=0.
  - On req_valid, latch the bounds:
  - x_lo = start_x>>C_L_H_SIZE.
  - x_hi = (start_x+blk_width)>>C_L_H_SIZE.
  - y_lo and y_hi are computed the same way with C_L_V_SIZE.
  - Load x_addr=x_lo, y_addr=y_lo, then go to ITER.
- Sum arithmetic: computed at width+1 bits. On carry out, clamp the hi bound to the all-ones line index. There is no wrap to line 0.
- ITER: line_valid=1. On line_valid&&line_ready:
  - If x_addr<x_hi: x_addr+1.
  - Else if y_addr<y_hi: x_addr=x_lo, y_addr+1.
  - Else (last line): go to IDLE.
- line_first=1 only for (x_lo,y_lo). line_last=1 only for (x_hi,y_hi). Both are 1 for a single-line request.
- Outputs hold stable while line_valid&&!line_ready.
- flush in any state: next state is IDLE and line_valid=0. flush overrides a simultaneous request or line handshake; a request presented together with flush is not accepted.
- Every emitted line overlaps the block. With default sizes there are at most 3×3 lines per request.

## Timing
- All outputs are registered.
- Reset values: req_ready=1, line_valid=0, x_addr=0, y_addr=0, line_first=0, line_last=0; FSM in IDLE.
- Request-to-first-line latency: 1 cycle. line_valid rises the cycle after the req handshake.
- Throughput: 1 line/cycle with line_ready held high.
- After the last-line handshake: IDLE next cycle, req_ready=1. This gives one bubble cycle between requests.
- Reset asserted mid-walk: immediate return to the reset values. No partial line is emitted after release.

## Configuration
- CACHE_LINE_ITER_COUNT_EN defined: adds output line_idx (4 bits).
  - Resets to 0 on every request accept.
  - Increments on each line handshake.
  - Presents the index of the current line (0..8).
  - Cleared by flush/reset.
- CACHE_LINE_ITER_COUNT_EN undefined: port and counter absent. All other behaviour is identical.

## Test plan
- Aligned single line: start_x=0, start_y=0, w=7, h=7, line_ready=1 -> one beat (0,0) with first=last=1, 1 cycle after accept. req_ready=1 two cycles after accept.
- Unaligned span: start_x=5, start_y=6, w=15, h=3 -> beats (0,0),(1,0),(2,0),(0,1),(1,1),(2,1) on consecutive cycles. first on beat 1, last on beat 6 only.
- Backpressure: same request, line_ready=0 for 3 cycles at beat 2 -> (1,0) held stable with line_valid=1. The sequence then resumes unchanged.
- Overflow clamp: start_x=4090, start_y=0, w=15, h=0 -> x_lo=511, x_hi clamped to 511. Single beat (511,0) with first=last=1.
- Flush mid-walk: flush asserted during beat 3 of the unaligned request -> line_valid=0 and req_ready=1 next cycle. A new request is then served from its own first line.
- Reset mid-walk: reset_n low during beat 4 -> all outputs take reset values immediately. Nothing is emitted after release until a new request arrives.
